// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 encodings and request legality check for the load/store unit
package lsu_pkg;

   localparam int DM_DEPTH_DFLT = 256;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_RD,
      S_LD_FMT,
      S_ST_RD,
      S_ST_MRG,
      S_ST_WR,
      S_RSP
   } lsu_state_e;

   // Illegal funct3 for the direction, or an access not aligned to its own size
   function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic bad_f3;
      bad_f3 = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
      return bad_f3 || (f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract/extend and store lane merge into a read word
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] b_mask;
   logic [31:0] h_mask;

   // Pick the addressed lane for loads and splice the store lane into the old word
   always_comb begin
      b         = 8'(word_i >> {off_i, 3'b000});
      h         = 16'(word_i >> {off_i[1], 4'b0000});
      b_mask    = 32'h0000_00FF << {off_i, 3'b000};
      h_mask    = 32'h0000_FFFF << {off_i[1], 4'b0000};
      ld_data_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
                  funct3_i == F3_BU ? {24'h0, b} :
                  funct3_i == F3_H  ? {{16{h[15]}}, h} :
                  funct3_i == F3_HU ? {16'h0, h} : word_i;
      st_word_o = funct3_i == F3_B ? (word_i & ~b_mask) | ({4{wdata_i[7:0]}} & b_mask) :
                  funct3_i == F3_H ? (word_i & ~h_mask) | ({2{wdata_i[15:0]}} & h_mask) : wdata_i;
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store sequencer with read-modify-write for sub-word stores
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DM_DEPTH = DM_DEPTH_DFLT,
   parameter int DM_AW    = $clog2(DM_DEPTH)
) (
   input  logic        clk_i,
   input  logic        LSUrst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_wdata_o,
   output logic        dm_wr_en_o,
   output logic        dm_rd_en_o,
   input  logic [31:0] dm_rdata_i
);

   lsu_state_e  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        dm_wr_en_q, dm_wr_en_d;
   logic        dm_rd_en_q, dm_rd_en_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] ld_data;
   logic [31:0] st_word;
   logic        unused_addr;

   assign unused_addr = ^req_addr_i[31:DM_AW+2];

   lsu_align u_align (
      .funct3_i  (funct3_q),
      .off_i     (off_q),
      .word_i    (dm_rdata_i),
      .wdata_i   (wdata_q),
      .ld_data_o (ld_data),
      .st_word_o (st_word)
   );

   // Sequencing: accept in IDLE, memory strobes and response are one-cycle pulses
   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      dm_addr_d   = dm_addr_q;
      dm_wdata_d  = dm_wdata_q;
      dm_wr_en_d  = 1'b0;
      dm_rd_en_d  = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
      case (state_q)
         S_IDLE: if (req_valid_i) begin
            funct3_d  = req_funct3_i;
            off_d     = req_addr_i[1:0];
            wdata_d   = req_wdata_i;
            dm_addr_d = 32'(req_addr_i[DM_AW+1:2]);
            if (req_err(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
               state_d     = S_RSP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else if (req_we_i && req_funct3_i == F3_W) begin
               state_d    = S_ST_WR;
               dm_wr_en_d = 1'b1;
               dm_wdata_d = req_wdata_i;
            end else begin
               state_d    = req_we_i ? S_ST_RD : S_LD_RD;
               dm_rd_en_d = 1'b1;
            end
         end
         S_LD_RD: state_d = S_LD_FMT;
         S_LD_FMT: begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_data;
         end
         S_ST_RD: state_d = S_ST_MRG;
         S_ST_MRG: begin
            state_d    = S_ST_WR;
            dm_wr_en_d = 1'b1;
            dm_wdata_d = st_word;
         end
         S_ST_WR: begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any request in flight
   always_ff @(posedge clk_i or posedge LSUrst_i) begin
      if (LSUrst_i) begin
         state_q     <= S_IDLE;
         funct3_q    <= 3'h0;
         off_q       <= 2'h0;
         wdata_q     <= 32'h0;
         dm_addr_q   <= 32'h0;
         dm_wdata_q  <= 32'h0;
         dm_wr_en_q  <= 1'b0;
         dm_rd_en_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         dm_addr_q   <= dm_addr_d;
         dm_wdata_q  <= dm_wdata_d;
         dm_wr_en_q  <= dm_wr_en_d;
         dm_rd_en_q  <= dm_rd_en_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready_o = state_q == S_IDLE;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign dm_addr_o   = dm_addr_q;
   assign dm_wdata_o  = dm_wdata_q;
   assign dm_wr_en_o  = dm_wr_en_q;
   assign dm_rd_en_o  = dm_rd_en_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory (256 x 32 bit, synchronous write, registered read).
- Accepts one load or store request at a time and converts the byte address to a word index.
- Performs read-modify-write for byte and halfword stores, because the memory only writes whole words.
- Aligns, sign-extends or zero-extends load data, and returns a single-cycle completion response.

Parameters:
DM_DEPTH, 256, data memory depth in words
DM_AW, 8, word-index width (log2 DM_DEPTH)

Ports:
clk_i  in  1  single clock, all state on rising edge
LSUrst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  LSU can accept (state IDLE)
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-justified
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  32  formatted load data; 0 for stores and errors
rsp_err_o  out  1  misaligned or illegal funct3, valid with rsp_valid_o
dm_addr_o  out  32  word index, zero-extended above DM_AW
dm_wdata_o  out  32  write word to memory
dm_wr_en_o  out  1  memory write enable
dm_rd_en_o  out  1  memory read enable
dm_rdata_i  in  32  memory read data, valid the cycle after dm_rd_en_o

Behaviour:
- Reset: state = IDLE. All outputs are 0 except req_ready_o = 1. Any in-flight request is dropped.
- Reset mid-operation: no dm_wr_en_o may be issued after release for a request accepted before reset.
- All dm_* and rsp_* outputs are registered. dm_wr_en_o and dm_rd_en_o are never both high.
- Acceptance: req_valid_i & req_ready_o at rising edge E0. The LSU latches we, funct3, addr and wdata.
- Word index: addr[DM_AW+1:2]. Upper bits are ignored and alias; 0x404 maps to word 1.
- Error checks at accept:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
  - On error: state goes to RSP. No memory access is made. In the cycle after E0: rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
- States: IDLE, LD_RD, LD_FMT, ST_RD, ST_MRG, ST_WR, RSP.
- Load path:
  - IDLE -> LD_RD: dm_rd_en_o = 1 and dm_addr_o valid during the cycle after E0.
  - LD_RD -> LD_FMT: dm_rdata_i valid. The selected byte or half (by addr[1:0] / addr[1]) is extended and registered.
  - LD_FMT -> RSP: rsp_valid_o = 1 with data.
  - Latency: rsp_valid_o high in the 3rd cycle after E0.
- SW path:
  - IDLE -> ST_WR: dm_wr_en_o = 1, dm_wdata_o = wdata in the cycle after E0.
  - ST_WR -> RSP: rsp_valid_o pulses in the 2nd cycle after E0.
- SB/SH path (read-modify-write):
  - IDLE -> ST_RD: read issued.
  - ST_RD -> ST_MRG: byte lanes addr[1:0] (SB) or halfword lane addr[1] (SH) of dm_rdata_i are replaced by wdata[7:0] or wdata[15:0]. The merged word is registered.
  - ST_MRG -> ST_WR: single-cycle write of the merged word.
  - ST_WR -> RSP: rsp_valid_o pulses in the 4th cycle after E0.
- RSP -> IDLE always. req_ready_o returns high the cycle after the pulse. Back-to-back requests are therefore spaced by the full op latency.
- A request presented while not ready is ignored. The requester holds it until accepted.
- Nothing is accepted in the RSP cycle.

Decomposition:
- Shared package lsu_pkg holds:
  - lsu_state_e enum.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - DM_DEPTH default.
- One natural combinational sub-module, lsu_align: load extract/extend and store lane merge, driven by funct3, addr[1:0], word and wdata.

Test Plan:
- Word 1 preloaded 0x8899AABB. LB addr 0x5 -> rsp_rdata_o 0xFFFFFFAA, rsp_valid_o 3 cycles after accept. LBU addr 0x5 -> 0x000000AA. LHU addr 0x6 -> 0x00008899.
- SH addr 0x6, wdata 0xFFFF1234 -> rd at cycle 1, single wr at cycle 3, dm_wdata_o 0x1234AABB. Follow-up LW addr 0x4 returns 0x1234AABB.
- SW addr 0x8, wdata 0xDEADBEEF -> dm_wr_en_o at cycle 1 only, dm_addr_o 2, dm_rd_en_o never high, rsp at cycle 2.
- LW addr 0x6, SH addr 0x3, and load funct3 011 -> rsp_err_o = 1 with rsp_valid_o at cycle 1, rdata 0, no dm_* activity.
- SB addr 0x4 with LSUrst_i pulsed in ST_MRG -> all outputs 0, req_ready_o 1, no dm_wr_en_o ever, word 1 unchanged.
- req_valid_i held high across two LW (addr 0x4, then 0x404) -> second accepted only after the first rsp; both return word 1.
